stack_tick_scheduler: RTL and testbench
=======================================

Name: stack_tick_scheduler

Overview:
Sequences the stacker game engine.
- Generates the single-cycle `timer` move pulse whose period shrinks as `lineNum` rises.
- Turns the raw drop button into a clean single-cycle `dropOut` pulse.
- Runs the game-phase FSM (idle/run/hold/over), so the engine sees ticks only while play is live.
- Sits between the board buttons and the GameEngine `timer`/`dropBtn` inputs.

Parameters:
- BASE_DIV, 16'd50000, tick period in clk cycles at line 0.
- STEP_DIV, 16'd4000, period reduction per line.
- MIN_DIV, 16'd8000, floor on tick period; must be ≥2.
- HOLD_CYC, 8'd16, cycles ticks and drops are suppressed after a forwarded drop.
- LINE_W, 4, width of `lineNum`.
- DEB_CYC, 16'd1000, debounce stability window; used only with DEBOUNCE_EN.

Ports:
- clk  in  1  system clock.
- rstBtn  in  1  asynchronous, active-low reset.
- dropBtn  in  1  raw player button, asynchronous to clk, active-high.
- lineNum  in  LINE_W  current stack line from the engine.
- EOG  in  1  end-of-game flag from the engine.
- timer  out  1  move tick to the engine, one cycle wide.
- dropOut  out  1  drop pulse to the engine, one cycle wide.
- running  out  1  high in RUN or HOLD.
- tickDiv  out  16  tick period currently in effect.

Behaviour:
- Reset (rstBtn=0, async): state=IDLE, divCnt=0, holdCnt=0, sync flops=0.
  - Outputs: timer=0, dropOut=0, running=0, tickDiv=BASE_DIV.
- Button path: 2-flop synchronizer s1→s2, then s2_d; press = s2 & ~s2_d.
  - dropBtn sampled high at edge N → press seen at edge N+2.
  - One press per rising level; holding the button gives no repeats.
- Divisor (combinational, 16-bit, no wrap):
  - prod = lineNum*STEP_DIV, computed at 16+LINE_W bits.
  - If prod ≥ BASE_DIV−MIN_DIV, tickDiv=MIN_DIV; otherwise tickDiv=BASE_DIV−prod.
- FSM:
  - IDLE:
    - press → RUN with divCnt=0.
    - The starting press is consumed; dropOut stays 0.
  - RUN:
    - divCnt increments each cycle.
    - At an edge where divCnt ≥ tickDiv−1: timer←1 for one cycle and divCnt←0.
    - Ticks are therefore every tickDiv cycles; the first tick is tickDiv cycles after entering RUN.
    - Press → dropOut←1 for one cycle, divCnt←0, holdCnt←0, go to HOLD.
  - HOLD:
    - timer=0; presses ignored; holdCnt increments.
    - At holdCnt=HOLD_CYC−1 → RUN with divCnt=0.
  - OVER:
    - timer=0, dropOut=0, running=0; presses ignored.
    - Sticky until reset.
- EOG=1 in RUN or HOLD → OVER on the next edge, with priority over every other transition. EOG is ignored in IDLE.
- Simultaneous tick and press in RUN: the drop wins and the tick is suppressed, so timer=0 and dropOut=1 that cycle.
- lineNum changes mid-count: the new tickDiv applies immediately. If divCnt already ≥ new tickDiv−1, the tick fires on the next edge; there is no lost or double tick.
- timer and dropOut are never high in the same cycle. Both are registered outputs.
- Reset asserted mid-RUN/HOLD: all state clears immediately; a pending tick or drop is discarded.

Optional Feature:
- Macro: STACK_TICK_DEBOUNCE_EN.
- Defined:
  - A 16-bit stability counter sits after s2.
  - The debounced level changes only after s2 has differed from it for DEB_CYC consecutive cycles.
  - Press = rising edge of the debounced level.
  - Press latency = N+2+DEB_CYC.
  - Glitches shorter than DEB_CYC produce no press.
- Undefined: press is taken directly from s2 as above, and DEB_CYC is unused.

Test Plan:
Settings for all tests: BASE_DIV=6, STEP_DIV=1, MIN_DIV=3, HOLD_CYC=4, LINE_W=4.
1. Reset, lineNum=0, single drop press → IDLE→RUN, dropOut stays 0; timer pulses every 6 cycles, first pulse 6 cycles after RUN entry; running=1.
2. In RUN, lineNum=2 → tickDiv=4, period 4. lineNum=5 → tickDiv=3 (clamped). lineNum=15 → tickDiv=3.
3. Drop press in RUN → dropOut high exactly 1 cycle at N+2. No timer for 4 HOLD cycles, then the next tick 6 cycles after RUN re-entry. A second press inside HOLD produces no dropOut.
4. Press timed so the sync edge lands on the cycle divCnt=5 → dropOut=1, timer=0 that cycle, counter restarts.
5. EOG=1 during RUN → timer/dropOut=0 from the next edge, running=0. Presses ignored until rstBtn pulsed low; after reset the scheduler is in IDLE with tickDiv=6.
6. STACK_TICK_DEBOUNCE_EN defined, DEB_CYC=5 → 3-cycle button glitch gives no dropOut; an 8-cycle hold gives one dropOut at N+7.

Source files
------------

// File: rtl/stack_tick_scheduler.sv
// -----------------------------------------------------------------------------
// stack_tick_scheduler
//
// Sequences the stacker game engine. It produces the single-cycle move tick
// (`timer`), whose period shrinks as the stack grows, and turns the raw drop
// button into a clean single-cycle `dropOut` pulse. A small game-phase FSM
// (IDLE / RUN / HOLD / OVER) gates both, so the engine only sees ticks while
// play is live.
//
// Ports:
//   clk      in   system clock
//   rstBtn   in   asynchronous active-low reset
//   dropBtn  in   raw player button, asynchronous to clk, active-high
//   lineNum  in   [LINE_W] current stack line from the engine
//   EOG      in   end-of-game flag from the engine
//   timer    out  move tick, one cycle wide (registered)
//   dropOut  out  drop pulse, one cycle wide (registered)
//   running  out  high in RUN or HOLD (registered)
//   tickDiv  out  [16] tick period currently in effect (combinational)
//
// Optional build macro: STACK_TICK_DEBOUNCE_EN
//   When defined, a DEB_CYC-cycle stability filter sits after the
//   synchronizer and the press is taken from the filtered level.
// -----------------------------------------------------------------------------
module stack_tick_scheduler #(
  parameter logic [15:0] BASE_DIV = 16'd50000,
  parameter logic [15:0] STEP_DIV = 16'd4000,
  parameter logic [15:0] MIN_DIV  = 16'd8000,
  parameter logic [7:0]  HOLD_CYC = 8'd16,
  parameter int          LINE_W   = 4
`ifdef STACK_TICK_DEBOUNCE_EN
  ,
  parameter logic [15:0] DEB_CYC  = 16'd1000
`endif
) (
  input  logic              clk,
  input  logic              rstBtn,
  input  logic              dropBtn,
  input  logic [LINE_W-1:0] lineNum,
  input  logic              EOG,
  output logic              timer,
  output logic              dropOut,
  output logic              running,
  output logic [15:0]       tickDiv
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_OVER = 2'd3
  } state_t;

  // Tick period for a given line. The product is formed wide enough that a
  // large line count can never wrap back into a long period.
  function automatic logic [15:0] calc_div(input logic [LINE_W-1:0] ln);
    logic [15+LINE_W:0] prod;
    logic [15+LINE_W:0] span;
    prod = {16'd0, ln} * {{LINE_W{1'b0}}, STEP_DIV};
    span = {{LINE_W{1'b0}}, BASE_DIV - MIN_DIV};
    if (prod >= span) calc_div = MIN_DIV;
    else              calc_div = BASE_DIV - prod[15:0];
  endfunction

  logic        r_s1;
  logic        r_s2;
  logic        w_press;
  logic [15:0] w_tickDiv;

  state_t      r_state;
  logic [15:0] r_divCnt;
  logic [7:0]  r_holdCnt;
  logic        r_timer;
  logic        r_drop;
  logic        r_run;

  assign w_tickDiv = calc_div(lineNum);

  // ---- button synchronizer --------------------------------------------------
  always_ff @(posedge clk or negedge rstBtn) begin
    if (!rstBtn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= dropBtn;
      r_s2 <= r_s1;
    end
  end

`ifdef STACK_TICK_DEBOUNCE_EN
  // ---- debounce filter ------------------------------------------------------
  // The filtered level only follows s2 once s2 has disagreed with it for
  // DEB_CYC consecutive cycles; any agreement restarts the count.
  logic        r_deb;
  logic        r_deb_d;
  logic [15:0] r_debCnt;

  always_ff @(posedge clk or negedge rstBtn) begin
    if (!rstBtn) begin
      r_deb    <= 1'b0;
      r_deb_d  <= 1'b0;
      r_debCnt <= 16'd0;
    end else begin
      r_deb_d <= r_deb;
      if (r_s2 != r_deb) begin
        if (r_debCnt == DEB_CYC - 16'd1) begin
          r_deb    <= r_s2;
          r_debCnt <= 16'd0;
        end else begin
          r_debCnt <= r_debCnt + 16'd1;
        end
      end else begin
        r_debCnt <= 16'd0;
      end
    end
  end

  assign w_press = r_deb & ~r_deb_d;
`else
  logic r_s2_d;

  always_ff @(posedge clk or negedge rstBtn) begin
    if (!rstBtn) r_s2_d <= 1'b0;
    else         r_s2_d <= r_s2;
  end

  assign w_press = r_s2 & ~r_s2_d;
`endif

  // ---- game-phase FSM -------------------------------------------------------
  // Pulse outputs default low every cycle so each is exactly one cycle wide.
  // In RUN the checks are ordered EOG, then press, then tick: a drop landing
  // on the tick cycle wins and the tick is dropped with the counter restart.
  always_ff @(posedge clk or negedge rstBtn) begin
    if (!rstBtn) begin
      r_state   <= S_IDLE;
      r_divCnt  <= 16'd0;
      r_holdCnt <= 8'd0;
      r_timer   <= 1'b0;
      r_drop    <= 1'b0;
      r_run     <= 1'b0;
    end else begin
      r_timer <= 1'b0;
      r_drop  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The starting press is consumed and never forwarded as a drop.
          if (w_press) begin
            r_state  <= S_RUN;
            r_divCnt <= 16'd0;
            r_run    <= 1'b1;
          end
        end
        S_RUN: begin
          if (EOG) begin
            r_state <= S_OVER;
            r_run   <= 1'b0;
          end else if (w_press) begin
            r_drop    <= 1'b1;
            r_divCnt  <= 16'd0;
            r_holdCnt <= 8'd0;
            r_state   <= S_HOLD;
          end else if (r_divCnt >= w_tickDiv - 16'd1) begin
            // >= rather than == so a shortened period fires at once.
            r_timer  <= 1'b1;
            r_divCnt <= 16'd0;
          end else begin
            r_divCnt <= r_divCnt + 16'd1;
          end
        end
        S_HOLD: begin
          if (EOG) begin
            r_state <= S_OVER;
            r_run   <= 1'b0;
          end else if (r_holdCnt == HOLD_CYC - 8'd1) begin
            r_state  <= S_RUN;
            r_divCnt <= 16'd0;
          end else begin
            r_holdCnt <= r_holdCnt + 8'd1;
          end
        end
        S_OVER: begin
          r_run <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_run   <= 1'b0;
        end
      endcase
    end
  end

  assign timer   = r_timer;
  assign dropOut = r_drop;
  assign running = r_run;
  assign tickDiv = w_tickDiv;

endmodule

// File: tb/tb_stack_tick_scheduler.sv
module tb_stack_tick_scheduler;

  localparam int BASE = 6;
  localparam int STEP = 1;
  localparam int MINP = 3;
  localparam int HOLD = 4;
  localparam int DEB  = 5;
`ifdef STACK_TICK_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rstBtn;
  logic        dropBtn;
  logic [3:0]  lineNum;
  logic        EOG;
  logic        timer;
  logic        dropOut;
  logic        running;
  logic [15:0] tickDiv;

  int errors = 0;
  int checks = 0;
  int ntick  = 0;
  int ndrop  = 0;

  stack_tick_scheduler #(
    .BASE_DIV(16'd6),
    .STEP_DIV(16'd1),
    .MIN_DIV (16'd3),
    .HOLD_CYC(8'd4),
    .LINE_W  (4)
`ifdef STACK_TICK_DEBOUNCE_EN
    ,
    .DEB_CYC (16'd5)
`endif
  ) dut (
    .clk    (clk),
    .rstBtn (rstBtn),
    .dropBtn(dropBtn),
    .lineNum(lineNum),
    .EOG    (EOG),
    .timer  (timer),
    .dropOut(dropOut),
    .running(running),
    .tickDiv(tickDiv)
  );

  always #5 clk = ~clk;

  // Behavioural model: game phase, cycles elapsed in the current tick period,
  // cycles of hold left, and the history of button samples.
  function automatic int period(input int ln);
    int p;
    p = ln * STEP;
    if (p >= BASE - MINP) return MINP;
    return BASE - p;
  endfunction

  int m_ph;       // 0 idle, 1 run, 2 hold, 3 over
  int m_el;
  int m_hl;
  bit m_smp [3];  // m_smp[i] = button sampled i+1 edges ago
  bit m_deb;
  bit m_debPrev;
  int m_diff;
  bit e_tmr;
  bit e_drp;
  bit e_run;
  int e_div;
  bit m_pr;

  always @(posedge clk) begin
    e_tmr = 1'b0;
    e_drp = 1'b0;
    if (!rstBtn) begin
      m_ph = 0; m_el = 0; m_hl = 0;
      m_smp[0] = 0; m_smp[1] = 0; m_smp[2] = 0;
      m_deb = 0; m_debPrev = 0; m_diff = 0;
    end else begin
`ifdef STACK_TICK_DEBOUNCE_EN
      m_pr = m_deb & ~m_debPrev;
      m_debPrev = m_deb;
      if (m_smp[1] != m_deb) begin
        m_diff++;
        if (m_diff == DEB) begin
          m_deb  = m_smp[1];
          m_diff = 0;
        end
      end else begin
        m_diff = 0;
      end
`else
      m_pr = m_smp[1] & ~m_smp[2];
`endif
      m_smp[2] = m_smp[1];
      m_smp[1] = m_smp[0];
      m_smp[0] = dropBtn;
      case (m_ph)
        0: if (m_pr) begin m_ph = 1; m_el = 0; end
        1: begin
          if (EOG) m_ph = 3;
          else if (m_pr) begin m_ph = 2; m_hl = HOLD; e_drp = 1'b1; end
          else begin
            m_el++;
            if (m_el >= period(int'(lineNum))) begin e_tmr = 1'b1; m_el = 0; end
          end
        end
        2: begin
          if (EOG) m_ph = 3;
          else begin
            m_hl--;
            if (m_hl == 0) begin m_ph = 1; m_el = 0; end
          end
        end
        default: ;
      endcase
    end
    e_run = (m_ph == 1) || (m_ph == 2);
    #1;
    e_div = period(int'(lineNum));
    checks++;
    if ({timer, dropOut, running, tickDiv} !== {e_tmr, e_drp, e_run, 16'(e_div)}) begin
      errors++;
      $display("FAIL cycle t=%0t: got timer=%b drop=%b run=%b div=%0d, want timer=%b drop=%b run=%b div=%0d",
               $time, timer, dropOut, running, tickDiv, e_tmr, e_drp, e_run, e_div);
    end
    if (timer === 1'b1) ntick++;
    if (dropOut === 1'b1) ndrop++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Counts posedges until the chosen output is seen high (0 timer, 1 dropOut,
  // 2 running); sampled 2 time units after the edge.
  task automatic wait_for(input int which, input int budget, output int n);
    bit hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < budget) begin
      @(posedge clk);
      #2;
      n++;
      case (which)
        0: hit = (timer === 1'b1);
        1: hit = (dropOut === 1'b1);
        default: hit = (running === 1'b1);
      endcase
    end
    if (!hit) begin
      errors++;
      checks++;
      $display("FAIL wait sel=%0d: no event within %0d cycles", which, budget);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  int n, t0, d0;

  initial begin
    rstBtn = 1'b1; dropBtn = 1'b0; EOG = 1'b0; lineNum = 4'd0;
    #1 rstBtn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst tickDiv", tickDiv, 6);
    chk("rst running", running, 0);
    chk("rst timer", timer, 0);
    chk("rst dropOut", dropOut, 0);
    rstBtn = 1'b1;
    @(negedge clk);

    // Start press: IDLE -> RUN, no drop forwarded.
    d0 = ndrop;
    dropBtn = 1'b1;
    wait_for(2, 40, n);
    chk("start latency", n, LAT + 1);
    chk("start dropOut", dropOut, 0);
    dropBtn = 1'b0;
    wait_for(0, 40, n);
    chk("first tick gap", n, 6);
    wait_for(0, 40, n);
    chk("tick period 6", n, 6);
    chk("start no drop", ndrop - d0, 0);

`ifndef STACK_TICK_DEBOUNCE_EN
    // Period follows lineNum, clamped at the floor.
    lineNum = 4'd2; #1;
    chk("div line2", tickDiv, 4);
    wait_for(0, 40, n); chk("period line2", n, 4);
    wait_for(0, 40, n); chk("period line2 b", n, 4);
    lineNum = 4'd5; #1;
    chk("div line5", tickDiv, 3);
    wait_for(0, 40, n); chk("period line5", n, 3);
    lineNum = 4'd15; #1;
    chk("div line15", tickDiv, 3);
    wait_for(0, 40, n); chk("period line15", n, 3);
    lineNum = 4'd0; #1;
    chk("div line0", tickDiv, 6);
    wait_for(0, 40, n); chk("period line0", n, 6);

    // Drop in RUN, then a second press inside HOLD that must be ignored.
    dropBtn = 1'b1; cyc(1); dropBtn = 1'b0;
    wait_for(1, 40, n);
    chk("drop latency", n, 2);
    chk("drop no timer", timer, 0);
    d0 = ndrop;
    dropBtn = 1'b1; cyc(1); dropBtn = 1'b0;
    wait_for(0, 40, n);
    chk("tick after hold", n, 9);
    chk("hold press ignored", ndrop - d0, 0);

    // Press landing on the tick cycle: drop wins, tick suppressed.
    cyc(3);
    dropBtn = 1'b1; cyc(1); dropBtn = 1'b0;
    wait_for(1, 40, n);
    chk("collide latency", n, 2);
    chk("collide timer", timer, 0);
    wait_for(0, 40, n);
    chk("collide next tick", n, 10);
`else
    // Glitch shorter than the window: no drop. Long hold: one drop.
    cyc(12);
    d0 = ndrop;
    dropBtn = 1'b1; cyc(3); dropBtn = 1'b0;
    cyc(15);
    chk("glitch no drop", ndrop - d0, 0);
    dropBtn = 1'b1;
    wait_for(1, 40, n);
    chk("deb drop latency", n, LAT + 1);
    cyc(1);
    dropBtn = 1'b0;
    chk("deb single drop", ndrop - d0, 1);
    wait_for(0, 40, n);
`endif

    // End of game: OVER is sticky, presses ignored until reset.
    EOG = 1'b1;
    cyc(1);
    chk("over running", running, 0);
    chk("over timer", timer, 0);
    t0 = ntick; d0 = ndrop;
    dropBtn = 1'b1; cyc(LAT + 4); dropBtn = 1'b0;
    cyc(15);
    chk("over no ticks", ntick - t0, 0);
    chk("over no drops", ndrop - d0, 0);
    chk("over still stopped", running, 0);
    @(negedge clk);
    rstBtn = 1'b0; EOG = 1'b0;
    #1;
    chk("rerst running", running, 0);
    chk("rerst tickDiv", tickDiv, 6);
    @(negedge clk);
    rstBtn = 1'b1;
    @(negedge clk);
    dropBtn = 1'b1;
    wait_for(2, 40, n);
    chk("restart latency", n, LAT + 1);
    dropBtn = 1'b0;

    // Reset in the middle of RUN clears everything at once.
    cyc(4);
    @(negedge clk);
    rstBtn = 1'b0;
    #1;
    chk("midrun rst running", running, 0);
    chk("midrun rst timer", timer, 0);
    @(negedge clk);
    rstBtn = 1'b1;
    cyc(10);
    chk("idle after rst", running, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
